// File: rtl/serial_word_assembler.sv
// serial_word_assembler
//   Receive side of a framed serial link. Bits shifted out of a remote
//   shift-register chain are collected here and rebuilt into parallel words.
//   Both shift directions of the chain are supported (MSB-first or LSB-first).
//   A completed word goes into a one-word holding register that feeds a
//   valid/ready consumer. The shift register keeps assembling the next word
//   while the holding register waits to be drained.
//
// Ports
//   CLK       in   clock, all state changes on posedge
//   RESET_N   in   asynchronous active-low reset
//   SIN       in   serial data bit
//   SVALID    in   SIN valid this cycle
//   SFRAME    in   with SVALID: first bit of a word
//   DIR       in   0 = MSB-first, 1 = LSB-first, sampled on the framing bit
//   CLEAR     in   synchronous flush of partial word, holding reg, OVERRUN
//   DOUT      out  holding register (assembled word)
//   DVALID    out  DOUT holds an undelivered word
//   DREADY    in   consumer takes DOUT when DVALID & DREADY
//   BUSY      out  a word is partially assembled
//   FRAMEERR  out  one-cycle pulse: SFRAME seen mid-word
//   OVERRUN   out  sticky: a completed word was dropped (holding reg full)
//
// State table
//   state | meaning
//   IDLE  | no partial word; waiting for a framing bit
//   SHIFT | partial word held; count_q bits received so far
//
// Word index 0 is the MSB. The vector is stored descending, so word index i
// lives at vector bit WIDTH-1-i and the numeric value reads naturally.

module serial_word_assembler #(
  parameter int WIDTH = 36
) (
  input  logic             CLK,
  input  logic             RESET_N,
  input  logic             SIN,
  input  logic             SVALID,
  input  logic             SFRAME,
  input  logic             DIR,
  input  logic             CLEAR,
  output logic [WIDTH-1:0] DOUT,
  output logic             DVALID,
  input  logic             DREADY,
  output logic             BUSY,
  output logic             FRAMEERR,
  output logic             OVERRUN
);

  localparam int CW = $clog2(WIDTH + 1);

  typedef enum logic {
    IDLE  = 1'b0,
    SHIFT = 1'b1
  } state_t;

  state_t           state_q, state_d;
  logic [CW-1:0]    count_q, count_d;
  logic [WIDTH-1:0] shreg_q, shreg_d;
  logic [WIDTH-1:0] dout_q, dout_d;
  logic             dir_q, dir_d;
  logic             dvalid_q, dvalid_d;
  logic             frameerr_q, frameerr_d;
  logic             overrun_q, overrun_d;

  logic             dir_eff;
  logic [WIDTH-1:0] shift_base;
  logic [WIDTH-1:0] shifted;

  always_comb begin
    state_d    = state_q;
    count_d    = count_q;
    shreg_d    = shreg_q;
    dout_d     = dout_q;
    dir_d      = dir_q;
    dvalid_d   = dvalid_q;
    frameerr_d = 1'b0;
    overrun_d  = overrun_q;

    // A framing bit starts from an empty register with the freshly sampled
    // direction; any partial word is thrown away.
    dir_eff    = SFRAME ? DIR : dir_q;
    shift_base = SFRAME ? '0 : shreg_q;

    // MSB-first: new bit enters at the LSB end and earlier bits climb
    // toward the MSB. LSB-first: new bit enters at the MSB end and earlier
    // bits fall toward the LSB.
    if (dir_eff) begin
      shifted = {SIN, shift_base[WIDTH-1:1]};
    end else begin
      shifted = {shift_base[WIDTH-2:0], SIN};
    end

    if (dvalid_q && DREADY) begin
      dvalid_d = 1'b0;
    end

    if (SVALID) begin
      if (SFRAME) begin
        frameerr_d = (state_q == SHIFT);
        dir_d      = DIR;
        shreg_d    = shifted;
        count_d    = CW'(1);
        state_d    = SHIFT;
      end else if (state_q == SHIFT) begin
        shreg_d = shifted;
        if (count_q == CW'(WIDTH - 1)) begin
          state_d = IDLE;
          count_d = '0;
          // Room exists if the holding reg is empty or drained this edge.
          if (!dvalid_q || DREADY) begin
            dout_d   = shifted;
            dvalid_d = 1'b1;
          end else begin
            overrun_d = 1'b1;
          end
        end else begin
          count_d = count_q + CW'(1);
        end
      end
    end

    // CLEAR wins over any bit or handshake on the same edge; DOUT is kept.
    if (CLEAR) begin
      state_d    = IDLE;
      count_d    = '0;
      shreg_d    = '0;
      dout_d     = dout_q;
      dir_d      = dir_q;
      dvalid_d   = 1'b0;
      frameerr_d = 1'b0;
      overrun_d  = 1'b0;
    end
  end

  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      state_q    <= IDLE;
      count_q    <= '0;
      shreg_q    <= '0;
      dout_q     <= '0;
      dir_q      <= 1'b0;
      dvalid_q   <= 1'b0;
      frameerr_q <= 1'b0;
      overrun_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      count_q    <= count_d;
      shreg_q    <= shreg_d;
      dout_q     <= dout_d;
      dir_q      <= dir_d;
      dvalid_q   <= dvalid_d;
      frameerr_q <= frameerr_d;
      overrun_q  <= overrun_d;
    end
  end

  assign DOUT     = dout_q;
  assign DVALID   = dvalid_q;
  assign BUSY     = (state_q == SHIFT);
  assign FRAMEERR = frameerr_q;
  assign OVERRUN  = overrun_q;

endmodule
